// File: rtl/vive_ram_pkg.sv
// vive_ram_pkg: shared widths, readout states and block layout
// for the decoded-pulse RAM readout path.
package vive_ram_pkg;
  localparam int BLOCK_W    = 41;
  localparam int DATA_W     = 17;
  localparam int TS_W       = 24;
  localparam int NB_W       = 8;
  localparam int MAX_BLOCKS = 196;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_RELEASE,
    S_WAIT_OUT,
    S_DONE
  } rd_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [TS_W-1:0]   ts;
  } block_t;

  function automatic logic [NB_W-1:0] clamp_nb(
    input logic [NB_W-1:0] nb,
    input logic [NB_W-1:0] lim
  );
    return (nb > lim) ? lim : nb;
  endfunction
endpackage

// File: rtl/handshake_watchdog.sv
// handshake_watchdog: counts cycles spent waiting on the RAM
// handshake and flags the cycle the wait reaches FETCH_TIMEOUT.
module handshake_watchdog #(
  parameter int FETCH_TIMEOUT = 64
) (
  input  logic clk_96MHz,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic timeout
);
  localparam int CW = $clog2(FETCH_TIMEOUT + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cur;

  // clear marks the first cycle of a new wait, so it counts from zero
  assign cur     = clear ? '0 : cnt;
  assign timeout = enable && (cur == CW'(FETCH_TIMEOUT - 1));

  // cycle counter for the current wait
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || timeout) begin
      cnt <= '0;
    end else begin
      cnt <= cur + CW'(1);
    end
  end
endmodule

// File: rtl/decoded_readout_ctrl.sv
// decoded_readout_ctrl: walks the decoded-pulse RAM fetch handshake
// for blocks 1..N and streams each block to the host link.
module decoded_readout_ctrl
  import vive_ram_pkg::BLOCK_W, vive_ram_pkg::NB_W,
         vive_ram_pkg::block_t, vive_ram_pkg::rd_state_e,
         vive_ram_pkg::S_IDLE, vive_ram_pkg::S_REQ,
         vive_ram_pkg::S_RELEASE, vive_ram_pkg::S_WAIT_OUT,
         vive_ram_pkg::S_DONE, vive_ram_pkg::clamp_nb;
#(
  parameter int MAX_BLOCKS    = 196,
  parameter int FETCH_TIMEOUT = 64
) (
  input  logic               clk_96MHz,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [NB_W-1:0]    avl_blocks_nb,
  input  logic [BLOCK_W-1:0] block_wanted,
  input  logic               data_ready,
  output logic [NB_W-1:0]    block_wanted_number,
  output logic [BLOCK_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               done,
  output logic               error
);
  rd_state_e       state;
  block_t          beat_q;
  logic [NB_W-1:0] n_total;
  logic [NB_W-1:0] idx;
  logic [NB_W-1:0] idx_nxt;
  logic [NB_W-1:0] nb_snap;
  logic            final_q;
  logic            wd_clr;
  logic            wd_en;
  logic            wd_to;
  logic            last_hit;
  logic            room;

  assign nb_snap  = clamp_nb(avl_blocks_nb, NB_W'(MAX_BLOCKS));
  assign idx_nxt  = idx + NB_W'(1);
  assign last_hit = (idx == n_total);
  assign room     = !out_valid || out_ready;
  assign wd_en    = (state == S_REQ) || (state == S_RELEASE);
  assign out_data = beat_q;

  handshake_watchdog #(
    .FETCH_TIMEOUT(FETCH_TIMEOUT)
  ) u_wd (
    .clk_96MHz(clk_96MHz),
    .reset    (reset),
    .clear    (wd_clr),
    .enable   (wd_en),
    .timeout  (wd_to)
  );

  // readout sequencer; index only ever moves nonzero -> 0 -> nonzero
  always_ff @(posedge clk_96MHz) begin
    if (reset) begin
      state               <= S_IDLE;
      n_total             <= '0;
      idx                 <= '0;
      final_q             <= 1'b0;
      wd_clr              <= 1'b0;
      block_wanted_number <= '0;
      beat_q              <= '0;
      out_valid           <= 1'b0;
      out_last            <= 1'b0;
      busy                <= 1'b0;
      done                <= 1'b0;
      error               <= 1'b0;
    end else begin
      done   <= 1'b0;
      wd_clr <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            n_total <= nb_snap;
            idx     <= NB_W'(1);
            busy    <= 1'b1;
            error   <= 1'b0;
            final_q <= 1'b0;
            wd_clr  <= 1'b1;
            if (nb_snap == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              block_wanted_number <= NB_W'(1);
              state               <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (abort) begin
            block_wanted_number <= '0;
            out_valid           <= 1'b0;
            final_q             <= 1'b1;
            wd_clr              <= 1'b1;
            state               <= S_RELEASE;
          end else if (wd_to) begin
            error               <= 1'b1;
            block_wanted_number <= '0;
            out_valid           <= 1'b0;
            done                <= 1'b1;
            state               <= S_DONE;
          end else if (data_ready) begin
            beat_q              <= block_wanted;
            out_valid           <= 1'b1;
            out_last            <= last_hit;
            block_wanted_number <= '0;
            wd_clr              <= 1'b1;
            state               <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (abort) begin
            out_valid <= 1'b0;
            final_q   <= 1'b1;
          end
          if (wd_to) begin
            error     <= 1'b1;
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (!data_ready) begin
            if (final_q || abort) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else if (last_hit) begin
              state <= S_WAIT_OUT;
            end else if (room) begin
              idx                 <= idx_nxt;
              block_wanted_number <= idx_nxt;
              wd_clr              <= 1'b1;
              state               <= S_REQ;
            end else begin
              state <= S_WAIT_OUT;
            end
          end
        end
        S_WAIT_OUT: begin
          if (abort) begin
            out_valid <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end else if (room) begin
            if (last_hit) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx                 <= idx_nxt;
              block_wanted_number <= idx_nxt;
              wd_clr              <= 1'b1;
              state               <= S_REQ;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
